vga_reg_writer: RTL and testbench



---
 rtl/vga_reg_pkg.sv | 34 +++
 rtl/vga_reg_writer_if.sv | 15 +
 rtl/sync_fifo.sv | 61 ++++++
 rtl/vga_reg_writer.sv | 123 ++++++++++++
 tb/tb_vga_reg_writer.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_reg_pkg.sv
// Shared types and constants for the VGA register writer: display register map,
// the queued-update record and the drain state machine encoding.
package vga_reg_pkg;

    localparam int REG_ADDR_W = 9;
    localparam int REG_DATA_W = 32;

    localparam int DINO_X     = 0;
    localparam int DINO_Y     = 1;
    localparam int JUMP_X     = 2;
    localparam int JUMP_Y     = 3;
    localparam int DUCK_X     = 4;
    localparam int DUCK_Y     = 5;
    localparam int CACTUS_X   = 6;
    localparam int CACTUS_Y   = 7;
    localparam int GODZILLA_X = 8;
    localparam int GODZILLA_Y = 9;
    localparam int MAX_ADDR   = GODZILLA_Y;

    // nop entries exist only to carry a batch boundary whose address was rejected
    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
        logic                  last;
        logic                  nop;
    } fifo_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_DONE
    } state_t;

endpackage

// File: rtl/vga_reg_writer_if.sv
// Update channel from the game-state engine: valid/ready handshake carrying
// one register write and a batch-end marker.
interface vga_reg_writer_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_data;
    logic              cmd_last;

    modport master (output cmd_valid, cmd_addr, cmd_data, cmd_last, input cmd_ready);
    modport slave  (input cmd_valid, cmd_addr, cmd_data, cmd_last, output cmd_ready);
endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with fall-through read: rdata shows the head entry so the
// consumer can register it in the same cycle it pops.
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end
endmodule

// File: rtl/vga_reg_writer.sv
// Queues display register updates and replays them to the Avalon-MM register
// port one committed batch at a time, only while vblank is high.
module vga_reg_writer #(
    parameter int DEPTH    = 16,
    parameter int ADDR_W   = vga_reg_pkg::REG_ADDR_W,
    parameter int DATA_W   = vga_reg_pkg::REG_DATA_W,
    parameter int MAX_ADDR = vga_reg_pkg::MAX_ADDR
) (
    input  logic              clk,
    input  logic              reset,
    vga_reg_writer_if.slave   cmd,
    input  logic              vblank,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] writedata,
    output logic              write,
    output logic              chipselect,
    output logic              busy,
    output logic              frame_done,
    output logic [7:0]        drop_count
);
    import vga_reg_pkg::*;

    localparam int ENTRY_W = $bits(fifo_entry_t);
    localparam int PB_W    = $clog2(DEPTH + 1);

    state_t              state_q;
    logic [PB_W-1:0]     pending_q, pending_d;
    logic [7:0]          drop_q, drop_d;
    logic [ADDR_W-1:0]   address_q;
    logic [DATA_W-1:0]   writedata_q;
    logic                write_q, frame_done_q;

    fifo_entry_t         push_entry, head;
    logic [ENTRY_W-1:0]  head_bits;
    logic [PB_W-1:0]     fifo_count;
    logic                fifo_full, fifo_empty;
    logic                accept, invalid, push, pop;

    assign cmd.cmd_ready = !fifo_full;
    assign head          = fifo_entry_t'(head_bits);

    always_comb begin
        accept          = cmd.cmd_valid && !fifo_full;
        invalid         = (cmd.cmd_addr > ADDR_W'(MAX_ADDR));
        // A rejected address still has to close its batch, so it is kept as a nop
        push            = accept && (!invalid || cmd.cmd_last);
        push_entry.addr = cmd.cmd_addr;
        push_entry.data = cmd.cmd_data;
        push_entry.last = cmd.cmd_last;
        push_entry.nop  = invalid;
        pop             = (state_q == ST_DRAIN) && vblank && !fifo_empty;

        pending_d = pending_q;
        case ({push && cmd.cmd_last, pop && head.last})
            2'b10:   pending_d = pending_q + PB_W'(1);
            2'b01:   pending_d = pending_q - PB_W'(1);
            default: pending_d = pending_q;
        endcase

        drop_d = drop_q;
        if (accept && invalid && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata (push_entry),
        .pop   (pop),
        .rdata (head_bits),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            pending_q    <= '0;
            drop_q       <= '0;
            address_q    <= '0;
            writedata_q  <= '0;
            write_q      <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            pending_q    <= pending_d;
            drop_q       <= drop_d;
            write_q      <= 1'b0;
            frame_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if ((pending_q != '0) && vblank) state_q <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (pop) begin
                        write_q     <= !head.nop;
                        address_q   <= head.addr;
                        writedata_q <= head.data;
                        if (head.last) state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    frame_done_q <= 1'b1;
                    state_q      <= ((pending_q != '0) && vblank) ? ST_DRAIN : ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign address    = address_q;
    assign writedata  = writedata_q;
    assign write      = write_q;
    assign chipselect = write_q;
    assign frame_done = frame_done_q;
    assign drop_count = drop_q;
    assign busy       = (fifo_count != '0) || write_q;
endmodule

// File: tb/tb_vga_reg_writer.sv
// Bench for vga_reg_writer: directed batches against a queue-based model of
// what the register port must show, checked every cycle on the falling edge.
module tb_vga_reg_writer;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        vblank;
    logic [8:0]  address;
    logic [31:0] writedata;
    logic        write, chipselect, busy, frame_done;
    logic [7:0]  drop_count;

    vga_reg_writer_if #(.ADDR_W(9), .DATA_W(32)) cmd_if ();

    vga_reg_writer dut (
        .clk        (clk),
        .reset      (reset),
        .cmd        (cmd_if),
        .vblank     (vblank),
        .address    (address),
        .writedata  (writedata),
        .write      (write),
        .chipselect (chipselect),
        .busy       (busy),
        .frame_done (frame_done),
        .drop_count (drop_count)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
    endtask

    // Model: stored entries in order, plus what the bus has shown so far
    typedef struct { int addr; int data; bit last; bit nop; } ent_t;
    typedef struct { int cyc; int addr; int data; } wlog_t;
    ent_t  exp_q[$];
    wlog_t wlog[$];
    int    fdlog[$];
    int    m_drops = 0, m_pending = 0;
    bit    prev_vblank = 0, batch_end = 0, in_batch = 0, warned = 0, mon_en = 0;
    bit    fd_exp, inv;
    ent_t  e;

    always @(negedge clk) begin
        if (mon_en) begin
            check("cs_eq_write", chipselect, write);
            fd_exp    = batch_end;
            batch_end = 0;
            if (write) begin
                check("write_in_vblank", prev_vblank, 1);
                check("write_committed", m_pending > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("write_addr", address, e.addr);
                    check("write_data", writedata, e.data);
                    check("write_not_nop", e.nop, 0);
                    if (e.last) begin
                        m_pending--;
                        batch_end = 1;
                        in_batch  = 0;
                    end else begin
                        in_batch = 1;
                    end
                end
                wlog.push_back('{cyc, int'(address), int'(writedata)});
            end
            // A nop batch end is invisible on the bus; frame_done is its only trace
            if (frame_done && !fd_exp && exp_q.size() > 0 && exp_q[0].nop) begin
                void'(exp_q.pop_front());
                m_pending--;
                fd_exp   = 1;
                in_batch = 0;
            end
            check("frame_done", frame_done, fd_exp);
            if (frame_done) fdlog.push_back(cyc);
            check("drop_count", drop_count, m_drops);
            if (!(exp_q.size() > 0 && exp_q[0].nop)) begin
                check("cmd_ready", cmd_if.cmd_ready, exp_q.size() < DEPTH);
                check("busy", busy, (exp_q.size() != 0) || write);
            end
            if (in_batch && !vblank && !warned) begin
                $display("WARN: vblank fell mid-batch at cycle %0d, batch split across frames", cyc);
                warned = 1;
            end
            if (!in_batch) warned = 0;

            // Effects of the coming rising edge
            if (reset) begin
                exp_q.delete();
                m_drops   = 0;
                m_pending = 0;
                batch_end = 0;
                in_batch  = 0;
            end else if (cmd_if.cmd_valid && cmd_if.cmd_ready) begin
                inv = (cmd_if.cmd_addr > 9);
                if (inv && m_drops < 255) m_drops++;
                if (!inv || cmd_if.cmd_last) begin
                    exp_q.push_back('{int'(cmd_if.cmd_addr), int'(cmd_if.cmd_data), cmd_if.cmd_last, inv});
                    if (cmd_if.cmd_last) m_pending++;
                end
            end
            prev_vblank = vblank;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input int a, input int d, input bit l);
        int n = 0;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_addr  = 9'(a);
        cmd_if.cmd_data  = 32'(d);
        cmd_if.cmd_last  = l;
        while (!cmd_if.cmd_ready && n < 50) begin
            tick(1);
            n++;
        end
        check("push_ready", cmd_if.cmd_ready, 1);
        tick(1);
        cmd_if.cmd_valid = 1'b0;
    endtask

    int k0, k1, wb, fb;

    initial begin
        reset = 1'b1;
        vblank = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_addr  = '0;
        cmd_if.cmd_data  = '0;
        cmd_if.cmd_last  = 1'b0;
        tick(3);
        reset = 1'b0;
        check("rst_address", address, 0);
        check("rst_writedata", writedata, 0);
        check("rst_write", write, 0);
        check("rst_chipselect", chipselect, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_drop_count", drop_count, 0);
        check("rst_busy", busy, 0);
        check("rst_cmd_ready", cmd_if.cmd_ready, 1);
        mon_en = 1;

        // Single batch released by vblank
        push(0, 120, 0);
        push(1, 88, 1);
        tick(5);
        check("t1_no_write_before_vblank", wlog.size(), 0);
        wb = wlog.size(); fb = fdlog.size();
        vblank = 1'b1; k0 = cyc;
        tick(6);
        check("t1_write_count", wlog.size() - wb, 2);
        check("t1_fd_count", fdlog.size() - fb, 1);
        if (wlog.size() >= wb + 2) begin
            check("t1_w0_addr", wlog[wb].addr, 0);
            check("t1_w0_data", wlog[wb].data, 120);
            check("t1_w0_latency", wlog[wb].cyc - k0, 2);
            check("t1_w1_addr", wlog[wb+1].addr, 1);
            check("t1_w1_data", wlog[wb+1].data, 88);
            check("t1_w1_latency", wlog[wb+1].cyc - k0, 3);
        end
        if (fdlog.size() > fb) check("t1_fd_latency", fdlog[fb] - k0, 4);

        // Uncommitted entry is held even in vblank
        wb = wlog.size();
        push(2, 50, 0);
        tick(100);
        check("t2_uncommitted_held", wlog.size() - wb, 0);
        push(3, 60, 1);
        tick(6);
        check("t2_write_count", wlog.size() - wb, 2);
        if (wlog.size() >= wb + 2) begin
            check("t2_w0_addr", wlog[wb].addr, 2);
            check("t2_w0_data", wlog[wb].data, 50);
            check("t2_w1_addr", wlog[wb+1].addr, 3);
            check("t2_w1_data", wlog[wb+1].data, 60);
        end
        vblank = 1'b0;
        tick(2);

        // Out-of-range addresses: one dropped, one kept as a batch-end nop
        push(12, 7, 0);
        push(4, 9, 0);
        push(15, 1, 1);
        tick(2);
        check("t3_drop_count", drop_count, 2);
        wb = wlog.size(); fb = fdlog.size();
        vblank = 1'b1; k0 = cyc;
        tick(8);
        check("t3_write_count", wlog.size() - wb, 1);
        if (wlog.size() > wb) begin
            check("t3_w_addr", wlog[wb].addr, 4);
            check("t3_w_data", wlog[wb].data, 9);
        end
        check("t3_fd_count", fdlog.size() - fb, 1);
        if (fdlog.size() > fb) check("t3_fd_latency", fdlog[fb] - k0, 4);
        vblank = 1'b0;
        tick(2);

        // Full FIFO with no batch end: producer deadlock until reset
        for (int i = 0; i < DEPTH; i++) push(i % 10, 300 + i, 0);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_addr  = 9'd5;
        cmd_if.cmd_data  = 32'd77;
        cmd_if.cmd_last  = 1'b1;
        check("t4_full_ready_low", cmd_if.cmd_ready, 0);
        tick(20);
        check("t4_deadlock_ready", cmd_if.cmd_ready, 0);
        check("t4_deadlock_busy", busy, 1);
        reset = 1'b1;
        cmd_if.cmd_valid = 1'b0;
        tick(1);
        reset = 1'b0;
        check("t4_post_reset_ready", cmd_if.cmd_ready, 1);
        check("t4_post_reset_busy", busy, 0);
        check("t4_post_reset_drops", drop_count, 0);

        // vblank falls mid-batch: 3 writes, pause, 3 more
        for (int i = 0; i < 6; i++) push(i, 200 + i, i == 5);
        wb = wlog.size(); fb = fdlog.size();
        vblank = 1'b1; k0 = cyc;
        tick(4);
        vblank = 1'b0;
        tick(10);
        check("t5_first_part", wlog.size() - wb, 3);
        check("t5_no_fd_yet", fdlog.size() - fb, 0);
        vblank = 1'b1; k1 = cyc;
        tick(8);
        check("t5_total", wlog.size() - wb, 6);
        check("t5_fd_count", fdlog.size() - fb, 1);
        if (wlog.size() >= wb + 6) begin
            for (int i = 0; i < 6; i++) begin
                check("t5_addr", wlog[wb+i].addr, i);
                check("t5_data", wlog[wb+i].data, 200 + i);
            end
            check("t5_resume_latency", wlog[wb+3].cyc - k1, 1);
            check("t5_last_write_cycle", wlog[wb+5].cyc - k1, 3);
        end
        if (fdlog.size() > fb) check("t5_fd_latency", fdlog[fb] - k1, 4);
        vblank = 1'b0;
        tick(2);

        // Reset during the second write of a batch
        push(6, 1, 0);
        push(7, 2, 0);
        push(8, 3, 0);
        push(9, 4, 1);
        wb = wlog.size();
        vblank = 1'b1;
        tick(3);
        check("t6_second_write_on_bus", write, 1);
        check("t6_second_write_addr", address, 7);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("t6_write_after_reset", write, 0);
        check("t6_drops_after_reset", drop_count, 0);
        check("t6_busy_after_reset", busy, 0);
        tick(20);
        check("t6_no_more_writes", wlog.size() - wb, 2);
        vblank = 1'b0;
        tick(2);

        // drop_count saturates at 255
        for (int i = 0; i < 260; i++) push(10 + (i % 20), i, 0);
        tick(2);
        check("t7_drop_saturated", drop_count, 255);
        check("t7_nothing_stored", busy, 0);

        tick(3);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
